// File: rtl/dmem_line_responder.sv
// Memory-side responder for line-wide DMEM requests: each line is serialised into
// 32-bit word accesses against an internal heap array, with one done pulse per request.
module dmem_line_responder #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    CACHE_LINE_SIZE = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 32'h9000_0000,
    parameter int                    MEM_WORDS       = 8192
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       S_DMEM_strobe,
    input  logic [ADDR_WIDTH-1:0]      S_DMEM_addr,
    input  logic                       S_DMEM_rw,
    input  logic [CACHE_LINE_SIZE-1:0] S_DMEM_datain,
    output logic                       S_DMEM_done,
    output logic [CACHE_LINE_SIZE-1:0] S_DMEM_dataout,
    output logic                       S_DMEM_range_err
);

    localparam int WPL        = CACHE_LINE_SIZE / 32;
    localparam int LINE_BYTES = CACHE_LINE_SIZE / 8;
    localparam int IDX_W      = $clog2(MEM_WORDS);
    localparam int SEL_W      = (WPL > 1) ? $clog2(WPL) : 1;
    localparam int CNT_W      = $clog2(WPL + 2);

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [ADDR_WIDTH:0]   ext_t;
    typedef logic [IDX_W-1:0]      idx_t;
    typedef logic [CNT_W-1:0]      cnt_t;

    localparam addr_t LINE_MASK = addr_t'(LINE_BYTES - 1);
    // One extra bit so a line near the top of the address space cannot wrap into range.
    localparam ext_t  LIMIT     = ext_t'(BASE_ADDR) + ext_t'(4 * MEM_WORDS);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    function automatic addr_t align_line(input addr_t a);
        return a & ~LINE_MASK;
    endfunction

    function automatic logic line_out_of_range(input addr_t a);
        addr_t al;
        al = align_line(a);
        return (al < BASE_ADDR) || ((ext_t'(al) + ext_t'(LINE_BYTES)) > LIMIT);
    endfunction

    function automatic idx_t line_index(input addr_t a);
        return idx_t'((align_line(a) - BASE_ADDR) >> 2);
    endfunction

    state_t                  state;
    cnt_t                    cnt;
    logic                    oor_q;
    idx_t                    base_idx_q;
    logic [WPL-1:0][31:0]    line_q;
    logic [31:0]             mem [MEM_WORDS];

    logic                    vld_p1;
    logic [31:0]             rd_word_p1;
    logic [SEL_W-1:0]        rd_sel_p1;

    logic                    accept;
    logic                    rd_issue;
    logic                    wr_issue;
    idx_t                    word_idx;

    assign accept   = (state == IDLE) && S_DMEM_strobe;
    assign rd_issue = (state == RD) && (cnt < cnt_t'(WPL)) && !oor_q;
    assign wr_issue = (state == WR) && (cnt < cnt_t'(WPL)) && !oor_q;
    assign word_idx = base_idx_q + idx_t'(cnt);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state            <= IDLE;
            cnt              <= '0;
            oor_q            <= 1'b0;
            vld_p1           <= 1'b0;
            S_DMEM_done      <= 1'b0;
            S_DMEM_range_err <= 1'b0;
            S_DMEM_dataout   <= '0;
        end else begin
            S_DMEM_done      <= 1'b0;
            S_DMEM_range_err <= 1'b0;
            vld_p1           <= rd_issue;
            case (state)
                IDLE: begin
                    if (S_DMEM_strobe) begin
                        cnt   <= '0;
                        oor_q <= line_out_of_range(S_DMEM_addr);
                        state <= S_DMEM_rw ? WR : RD;
                    end
                end
                RD: begin
                    // Two extra counts drain the one-cycle read latency before done.
                    if (cnt == cnt_t'(WPL + 1)) begin
                        state            <= DONE;
                        S_DMEM_done      <= 1'b1;
                        S_DMEM_range_err <= oor_q;
                        S_DMEM_dataout   <= oor_q ? '0 : line_q;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WR: begin
                    if (cnt == cnt_t'(WPL)) begin
                        state            <= DONE;
                        S_DMEM_done      <= 1'b1;
                        S_DMEM_range_err <= oor_q;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Stage p0 -> p1: array read issued, word returns one cycle later.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            line_q     <= S_DMEM_datain;
            base_idx_q <= line_index(S_DMEM_addr);
        end else if (vld_p1) begin
            line_q[rd_sel_p1] <= rd_word_p1;
        end
        if (rd_issue) begin
            rd_word_p1 <= mem[word_idx];
            rd_sel_p1  <= cnt[SEL_W-1:0];
        end
        if (wr_issue) begin
            mem[word_idx] <= line_q[cnt[SEL_W-1:0]];
        end
    end

endmodule

// File: tb/tb_dmem_line_responder.sv
// Directed bench for dmem_line_responder: latency, data integrity, strobe holding,
// range limits and mid-write reset.
module tb_dmem_line_responder;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         S_DMEM_strobe = 1'b0;
    logic [31:0]  S_DMEM_addr = '0;
    logic         S_DMEM_rw = 1'b0;
    logic [255:0] S_DMEM_datain = '0;
    logic         S_DMEM_done;
    logic [255:0] S_DMEM_dataout;
    logic         S_DMEM_range_err;

    int checks = 0;
    int errors = 0;

    dmem_line_responder dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .S_DMEM_strobe    (S_DMEM_strobe),
        .S_DMEM_addr      (S_DMEM_addr),
        .S_DMEM_rw        (S_DMEM_rw),
        .S_DMEM_datain    (S_DMEM_datain),
        .S_DMEM_done      (S_DMEM_done),
        .S_DMEM_dataout   (S_DMEM_dataout),
        .S_DMEM_range_err (S_DMEM_range_err)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mk_line(input logic [31:0] base, input logic [31:0] step);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = base + step * i;
        return l;
    endfunction

    // Issues one request, waits for done, checks latency, range_err and the single-cycle pulse.
    task automatic do_req(input string tag, input logic rw, input logic [31:0] addr,
                          input logic [255:0] wdata, input int exp_lat, input logic exp_err,
                          output logic [255:0] rdata);
        int   lat;
        logic seen;
        @(negedge clk_i);
        S_DMEM_strobe = 1'b1;
        S_DMEM_rw     = rw;
        S_DMEM_addr   = addr;
        S_DMEM_datain = wdata;
        @(posedge clk_i);
        #1 S_DMEM_strobe = 1'b0;
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < 40) begin
            @(posedge clk_i);
            #1;
            lat++;
            if (S_DMEM_done) seen = 1'b1;
        end
        check({tag, "_done"}, seen, 1);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_err"}, S_DMEM_range_err, exp_err);
        rdata = S_DMEM_dataout;
        @(posedge clk_i);
        #1;
        check({tag, "_pulse"}, S_DMEM_done, 0);
    endtask

    logic [255:0] rd;
    logic [255:0] line_b;
    logic [255:0] exp5;
    int           ndone;
    int           first_edge;
    int           second_edge;
    int           k;
    logic         seen;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_done", S_DMEM_done, 0);
        check("rst_dataout", S_DMEM_dataout, 0);
        check("rst_err", S_DMEM_range_err, 0);
        @(negedge clk_i) rst_i = 1'b0;

        // Write then read back an incrementing line.
        do_req("t1_wr", 1'b1, 32'h9000_0040, mk_line(0, 1), 9, 1'b0, rd);
        do_req("t1_rd", 1'b0, 32'h9000_0040, '0, 10, 1'b0, rd);
        check("t1_data", rd, mk_line(0, 1));

        // Unaligned address maps to the same line.
        do_req("t2_rd", 1'b0, 32'h9000_005C, '0, 10, 1'b0, rd);
        check("t2_data", rd, mk_line(0, 1));

        // Read accepted on the first IDLE cycle after a write's done.
        do_req("t6_wr", 1'b1, 32'h9000_0200, mk_line(32'hA0A0_0000, 1), 9, 1'b0, rd);
        do_req("t6_rd", 1'b0, 32'h9000_0200, '0, 10, 1'b0, rd);
        check("t6_data", rd, mk_line(32'hA0A0_0000, 1));

        // Level-held strobe: accepts at edges 0, 12, 24; dones at 10, 22, 34.
        @(negedge clk_i);
        S_DMEM_strobe = 1'b1;
        S_DMEM_rw     = 1'b0;
        S_DMEM_addr   = 32'h9000_0000;
        ndone = 0;
        first_edge = -1;
        second_edge = -1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk_i);
            #1;
            if (S_DMEM_done) begin
                ndone++;
                if (first_edge < 0) first_edge = c;
                else if (second_edge < 0) second_edge = c;
            end
        end
        @(negedge clk_i) S_DMEM_strobe = 1'b0;
        check("t3_count", ndone, 2);
        check("t3_first", first_edge, 10);
        check("t3_second", second_edge, 22);
        k = 29;
        seen = 1'b0;
        while (!seen && k < 50) begin
            @(posedge clk_i);
            #1;
            k++;
            if (S_DMEM_done) seen = 1'b1;
        end
        check("t3_drain", k, 34);
        @(posedge clk_i);
        #1;

        // Range boundaries.
        do_req("t4_wr_lo", 1'b1, 32'h8FFF_FFE0, mk_line(32'h5555_0000, 1), 9, 1'b1, rd);
        do_req("t4_wr_hi", 1'b1, 32'h9000_8000, mk_line(32'h6666_0000, 1), 9, 1'b1, rd);
        do_req("t4_wr_last", 1'b1, 32'h9000_7FE0, mk_line(32'h7777_0000, 1), 9, 1'b0, rd);
        do_req("t4_rd_last", 1'b0, 32'h9000_7FE0, '0, 10, 1'b0, rd);
        check("t4_last_data", rd, mk_line(32'h7777_0000, 1));
        do_req("t4_rd_hi", 1'b0, 32'h9000_8000, '0, 10, 1'b1, rd);
        check("t4_hi_data", rd, 0);
        do_req("t4_rd_lo", 1'b0, 32'h8FFF_FFE0, '0, 10, 1'b1, rd);
        do_req("t4_rd_top", 1'b0, 32'hFFFF_FFE0, '0, 10, 1'b1, rd);
        check("t4_top_data", rd, 0);

        // Mid-write reset: only the first four words land.
        line_b = mk_line(32'h0000_1000, 1);
        do_req("t5_wr_b", 1'b1, 32'h9000_0100, line_b, 9, 1'b0, rd);
        do_req("t5_rd_b", 1'b0, 32'h9000_0100, '0, 10, 1'b0, rd);
        check("t5_b_data", rd, line_b);
        @(negedge clk_i);
        S_DMEM_strobe = 1'b1;
        S_DMEM_rw     = 1'b1;
        S_DMEM_addr   = 32'h9000_0100;
        S_DMEM_datain = {256{1'b1}};
        @(posedge clk_i);
        #1 S_DMEM_strobe = 1'b0;
        repeat (4) @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        check("t5_rst_done", S_DMEM_done, 0);
        check("t5_rst_dataout", S_DMEM_dataout, 0);
        check("t5_rst_err", S_DMEM_range_err, 0);
        @(posedge clk_i);
        #1;
        check("t5_hold_done", S_DMEM_done, 0);
        @(negedge clk_i) rst_i = 1'b0;
        repeat (10) begin
            @(posedge clk_i);
            #1;
            check("t5_no_done", S_DMEM_done, 0);
        end
        exp5 = line_b;
        for (int i = 0; i < 4; i++) exp5[32*i +: 32] = 32'hFFFF_FFFF;
        do_req("t5_rd", 1'b0, 32'h9000_0100, '0, 10, 1'b0, rd);
        check("t5_data", rd, exp5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
